reg_rename_file: RTL and testbench

- Parametrised architectural register file with per-register rename status (dirty bit and ROB tag).
- Sits between decoder, ROB and issue logic.
- Successor to the single-snapshot status file. Adds NUM_RD operand read ports, a same-cycle commit bypass and a circular checkpoint stack.
- The checkpoint stack saves and restores rename state on branch issue and mispredict, so a mispredict no longer needs a full flush.

---
 rtl/reg_rename_file.sv | 224 ++++++++++++++++++++++
 tb/tb_reg_rename_file.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename status.
// Multi-port operand reads, commit bypass and a circular checkpoint stack.
module reg_rename_file #(
  parameter int XLEN     = 32,
  parameter int REG_BIT  = 5,
  parameter int ROB_BIT  = 4,
  parameter int NUM_RD   = 2,
  parameter int CKPT_BIT = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear_in,
  input  logic                      commit_valid,
  input  logic [REG_BIT-1:0]        commit_reg_id,
  input  logic [XLEN-1:0]           commit_data,
  input  logic [ROB_BIT-1:0]        commit_rob_entry,
  input  logic                      issue_valid,
  input  logic [REG_BIT-1:0]        issue_reg_id,
  input  logic [ROB_BIT-1:0]        issue_rob_entry,
  input  logic [NUM_RD*REG_BIT-1:0] rd_id,
  output logic [NUM_RD*XLEN-1:0]    rd_val,
  output logic [NUM_RD-1:0]         rd_has_dep,
  output logic [NUM_RD*ROB_BIT-1:0] rd_dep,
  output logic [NUM_RD*ROB_BIT-1:0] rob_query_entry,
  input  logic [NUM_RD-1:0]         rob_query_ready,
  input  logic [NUM_RD*XLEN-1:0]    rob_query_value,
  input  logic                      ckpt_save,
  output logic [CKPT_BIT-1:0]       ckpt_id_out,
  output logic                      ckpt_full,
  input  logic                      ckpt_restore,
  input  logic [CKPT_BIT-1:0]       ckpt_restore_id,
  input  logic                      ckpt_release
);

  localparam int NUM_REGS = 2 ** REG_BIT;
  localparam int NUM_CKPT = 2 ** CKPT_BIT;

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] dirty;
  logic [ROB_BIT-1:0]  tags [NUM_REGS];

  logic [NUM_REGS-1:0] ck_dirty [NUM_CKPT];
  logic [ROB_BIT-1:0]  ck_tags [NUM_CKPT][NUM_REGS];

  logic [CKPT_BIT-1:0] head;
  logic [CKPT_BIT-1:0] tail;
  logic [CKPT_BIT-1:0] head_nx;
  logic [CKPT_BIT:0]   count;

  logic commit_wr;
  logic issue_wr;
  logic live_hit;
  logic ck_full;
  logic rel_ok;
  logic save_ok;

  logic [NUM_REGS-1:0] nx_dirty;
  logic [ROB_BIT-1:0]  nx_tags [NUM_REGS];
  logic [NUM_REGS-1:0] cl_dirty [NUM_CKPT];
  logic [ROB_BIT-1:0]  cl_tags [NUM_CKPT][NUM_REGS];

  assign commit_wr = commit_valid && (commit_reg_id != '0);
  assign issue_wr  = issue_valid && (issue_reg_id != '0);
  assign live_hit  = commit_wr &&
                     (tags[commit_reg_id] == commit_rob_entry);
  assign ck_full   = (count == (CKPT_BIT+1)'(NUM_CKPT));
  assign rel_ok    = ckpt_release && (count != '0);
  assign save_ok   = ckpt_save && !ck_full && !ckpt_restore;
  assign head_nx   = head + CKPT_BIT'(rel_ok);

  assign ckpt_full   = ck_full;
  assign ckpt_id_out = tail;

  // Next live rename state: commit clear first, then issue wins
  always_comb begin
    nx_dirty = dirty;
    nx_tags  = tags;
    if (live_hit) begin
      nx_dirty[commit_reg_id] = 1'b0;
      nx_tags[commit_reg_id]  = '0;
    end
    if (issue_wr) begin
      nx_dirty[issue_reg_id] = 1'b1;
      nx_tags[issue_reg_id]  = issue_rob_entry;
    end
  end

  // Each checkpoint slot with this cycle's commit clear applied
  always_comb begin
    for (int s = 0; s < NUM_CKPT; s++) begin
      cl_dirty[s] = ck_dirty[s];
      cl_tags[s]  = ck_tags[s];
      if (commit_wr &&
          ck_tags[s][commit_reg_id] == commit_rob_entry) begin
        cl_dirty[s][commit_reg_id] = 1'b0;
        cl_tags[s][commit_reg_id]  = '0;
      end
    end
  end

  // Register values: only commits write them
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (rdy_in && commit_wr) begin
      regs[commit_reg_id] <= commit_data;
    end
  end

  // Live dirty/tag: flush, restore from a slot, or normal update
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dirty <= '0;
      for (int i = 0; i < NUM_REGS; i++) tags[i] <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        dirty <= '0;
        for (int i = 0; i < NUM_REGS; i++) tags[i] <= '0;
      end else if (ckpt_restore) begin
        dirty <= cl_dirty[ckpt_restore_id];
        tags  <= cl_tags[ckpt_restore_id];
      end else begin
        dirty <= nx_dirty;
        tags  <= nx_tags;
      end
    end
  end

  // Checkpoint slots: snapshot at tail, otherwise track commits
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        ck_dirty[s] <= '0;
        for (int i = 0; i < NUM_REGS; i++) ck_tags[s][i] <= '0;
      end
    end else if (rdy_in && !clear_in) begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        if (save_ok && tail == CKPT_BIT'(s)) begin
          ck_dirty[s] <= nx_dirty;
          ck_tags[s]  <= nx_tags;
        end else begin
          ck_dirty[s] <= cl_dirty[s];
          ck_tags[s]  <= cl_tags[s];
        end
      end
    end
  end

  // Stack pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (ckpt_restore) begin
        head  <= head_nx;
        tail  <= ckpt_restore_id;
        count <= {1'b0, ckpt_restore_id - head_nx};
      end else begin
        head  <= head_nx;
        tail  <= tail + CKPT_BIT'(save_ok);
        count <= count + (CKPT_BIT+1)'(save_ok)
                       - (CKPT_BIT+1)'(rel_ok);
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [REG_BIT-1:0] r;
    logic [ROB_BIT-1:0] t;
    logic [XLEN-1:0]    v;
    logic               h;

    assign r = rd_id[k*REG_BIT +: REG_BIT];
    assign t = tags[r];

    // Operand resolution: x0, commit bypass, ROB forward, file
    always_comb begin
      v = '0;
      h = 1'b0;
      if (r == '0) begin
        v = '0;
      end else if (commit_valid && commit_reg_id == r &&
                   dirty[r] && t == commit_rob_entry) begin
        v = commit_data;
      end else if (dirty[r]) begin
        if (rob_query_ready[k]) begin
          v = rob_query_value[k*XLEN +: XLEN];
        end else begin
          h = 1'b1;
        end
      end else begin
        v = regs[r];
      end
    end

    assign rd_val[k*XLEN +: XLEN]             = v;
    assign rd_has_dep[k]                      = h;
    assign rd_dep[k*ROB_BIT +: ROB_BIT]          = t;
    assign rob_query_entry[k*ROB_BIT +: ROB_BIT] = t;
  end

`ifndef SYNTHESIS
  // Illegal checkpoint usage is dropped by the logic and flagged here
  always @(posedge clk_in) begin
    if (rst_in && rdy_in && !clear_in) begin
      assert (!(ckpt_save && !ckpt_restore && ck_full))
        else $warning("checkpoint save dropped: stack full");
      assert (!(ckpt_release && count == '0))
        else $warning("checkpoint release ignored: stack empty");
      assert (!(ckpt_restore && ckpt_release &&
                ckpt_restore_id == head))
        else $warning("restore to slot released this cycle");
    end
  end
`endif

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: directed vector table, async reset and
// randomized traffic against a queue-based rename model.
module tb_reg_rename_file;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        commit_valid;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_data;
  logic [3:0]  commit_rob_entry;
  logic        issue_valid;
  logic [4:0]  issue_reg_id;
  logic [3:0]  issue_rob_entry;
  logic [9:0]  rd_id;
  logic [63:0] rd_val;
  logic [1:0]  rd_has_dep;
  logic [7:0]  rd_dep;
  logic [7:0]  rob_query_entry;
  logic [1:0]  rob_query_ready;
  logic [63:0] rob_query_value;
  logic        ckpt_save;
  logic [1:0]  ckpt_id_out;
  logic        ckpt_full;
  logic        ckpt_restore;
  logic [1:0]  ckpt_restore_id;
  logic        ckpt_release;

  reg_rename_file dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .clear_in         (clear_in),
    .commit_valid     (commit_valid),
    .commit_reg_id    (commit_reg_id),
    .commit_data      (commit_data),
    .commit_rob_entry (commit_rob_entry),
    .issue_valid      (issue_valid),
    .issue_reg_id     (issue_reg_id),
    .issue_rob_entry  (issue_rob_entry),
    .rd_id            (rd_id),
    .rd_val           (rd_val),
    .rd_has_dep       (rd_has_dep),
    .rd_dep           (rd_dep),
    .rob_query_entry  (rob_query_entry),
    .rob_query_ready  (rob_query_ready),
    .rob_query_value  (rob_query_value),
    .ckpt_save        (ckpt_save),
    .ckpt_id_out      (ckpt_id_out),
    .ckpt_full        (ckpt_full),
    .ckpt_restore     (ckpt_restore),
    .ckpt_restore_id  (ckpt_restore_id),
    .ckpt_release     (ckpt_release)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rdy, clr, cv;
    logic [4:0]  creg;
    logic [31:0] cdata;
    logic [3:0]  ctag;
    logic        iv;
    logic [4:0]  ireg;
    logic [3:0]  itag;
    logic        sv, rl, rs;
    logic [1:0]  rid;
    logic [4:0]  r0, r1;
    logic        qrdy;
    logic [31:0] qval;
    logic [31:0] ev0;
    logic        eh0;
    logic [3:0]  ed0;
    logic [31:0] ev1;
    logic        eh1;
    logic        efull;
    logic [1:0]  eid;
  } vec_t;

  localparam int NV = 39;
  vec_t tv [NV];

  typedef struct packed {
    logic [1:0]       id;
    logic [31:0]      d;
    logic [31:0][3:0] t;
  } snap_t;

  logic [31:0]      m_r [32];
  logic [31:0]      m_d;
  logic [31:0][3:0] m_t;
  snap_t            m_q [$];
  logic [1:0]       m_tail;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rdy_in = 1; clear_in = 0;
    commit_valid = 0; commit_reg_id = 0;
    commit_data = 0; commit_rob_entry = 0;
    issue_valid = 0; issue_reg_id = 0; issue_rob_entry = 0;
    ckpt_save = 0; ckpt_release = 0;
    ckpt_restore = 0; ckpt_restore_id = 0;
    rd_id = 0; rob_query_ready = 0; rob_query_value = 0;
  endtask

  task automatic drive(input vec_t v);
    rdy_in = v.rdy; clear_in = v.clr;
    commit_valid = v.cv; commit_reg_id = v.creg;
    commit_data = v.cdata; commit_rob_entry = v.ctag;
    issue_valid = v.iv; issue_reg_id = v.ireg;
    issue_rob_entry = v.itag;
    ckpt_save = v.sv; ckpt_release = v.rl;
    ckpt_restore = v.rs; ckpt_restore_id = v.rid;
    rd_id = {v.r1, v.r0};
    rob_query_ready = {2{v.qrdy}};
    rob_query_value = {2{v.qval}};
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_r[i] = '0;
    m_d = '0; m_t = '0; m_tail = '0;
    m_q.delete();
  endtask

  // Expected operand from the rename rules applied to model state
  task automatic m_read(input logic [4:0] r, input logic qr,
                        input logic [31:0] qv, output logic [31:0] v,
                        output logic h, output logic [3:0] d);
    d = m_t[r]; v = '0; h = 1'b0;
    if (r == 0) v = '0;
    else if (commit_valid && commit_reg_id == r && m_d[r] &&
             m_t[r] == commit_rob_entry) v = commit_data;
    else if (m_d[r]) begin
      if (qr) v = qv;
      else h = 1'b1;
    end else v = m_r[r];
  endtask

  // One clock of the model using the currently driven inputs
  task automatic m_step();
    logic [31:0]      nd;
    logic [31:0][3:0] nt;
    logic             cw;
    snap_t            s;
    int               k;
    if (!rdy_in) return;
    cw = commit_valid && commit_reg_id != 0;
    if (clear_in) begin
      m_d = '0; m_t = '0; m_tail = '0;
      m_q.delete();
    end else begin
      nd = m_d; nt = m_t;
      if (cw && nt[commit_reg_id] == commit_rob_entry) begin
        nd[commit_reg_id] = 0; nt[commit_reg_id] = 0;
      end
      if (issue_valid && issue_reg_id != 0) begin
        nd[issue_reg_id] = 1; nt[issue_reg_id] = issue_rob_entry;
      end
      for (int i = 0; i < m_q.size(); i++) begin
        s = m_q[i];
        if (cw && s.t[commit_reg_id] == commit_rob_entry) begin
          s.d[commit_reg_id] = 0; s.t[commit_reg_id] = 0;
        end
        m_q[i] = s;
      end
      if (ckpt_restore) begin
        if (ckpt_release && m_q.size() > 0) void'(m_q.pop_front());
        k = -1;
        for (int i = 0; i < m_q.size(); i++)
          if (m_q[i].id == ckpt_restore_id) k = i;
        chk("model_restore_slot_valid", 64'(k >= 0), 64'd1);
        if (k >= 0) begin
          m_d = m_q[k].d; m_t = m_q[k].t;
          while (m_q.size() > k) void'(m_q.pop_back());
        end
        m_tail = ckpt_restore_id;
      end else begin
        if (ckpt_save && m_q.size() < 4) begin
          s.id = m_tail; s.d = nd; s.t = nt;
          m_q.push_back(s);
          m_tail = m_tail + 2'd1;
        end
        if (ckpt_release && m_q.size() > 0) void'(m_q.pop_front());
        m_d = nd; m_t = nt;
      end
    end
    if (cw) m_r[commit_reg_id] = commit_data;
  endtask

  initial begin
    // rdy clr cv creg cdata ctag | iv ireg itag | sv rl rs rid |
    // r0 r1 qrdy qval | ev0 eh0 ed0 ev1 eh1 full id
    tv[0]  = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 5,5,0,0, 0,0,0,0,0, 0,0};
    tv[1]  = '{1,0,1,0,'hFFFF,0, 0,0,0, 0,0,0,0, 0,5,0,0,
               0,0,0,0,0, 0,0};
    tv[2]  = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0};
    tv[3]  = '{1,0,0,0,0,0, 1,3,7, 0,0,0,0, 3,0,0,0, 0,0,0,0,0, 0,0};
    tv[4]  = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 3,3,0,0, 0,1,7,0,1, 0,0};
    tv[5]  = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 3,3,1,'h1234,
               'h1234,0,7,'h1234,0, 0,0};
    tv[6]  = '{1,0,1,3,'h1234,7, 0,0,0, 0,0,0,0, 3,3,0,0,
               'h1234,0,7,'h1234,0, 0,0};
    tv[7]  = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 3,3,0,0,
               'h1234,0,0,'h1234,0, 0,0};
    tv[8]  = '{1,0,0,0,0,0, 1,3,2, 0,0,0,0, 3,3,0,0,
               'h1234,0,0,'h1234,0, 0,0};
    tv[9]  = '{1,0,0,0,0,0, 1,3,5, 0,0,0,0, 3,3,0,0, 0,1,2,0,1, 0,0};
    tv[10] = '{1,0,1,3,'hAA,2, 0,0,0, 0,0,0,0, 3,3,0,0,
               0,1,5,0,1, 0,0};
    tv[11] = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 3,3,0,0, 0,1,5,0,1, 0,0};
    tv[12] = '{1,0,0,0,0,0, 1,4,1, 0,0,0,0, 4,3,0,0, 0,0,0,0,1, 0,0};
    tv[13] = '{1,0,0,0,0,0, 0,0,0, 1,0,0,0, 4,3,0,0, 0,1,1,0,1, 0,0};
    tv[14] = '{1,0,0,0,0,0, 1,4,3, 0,0,0,0, 4,3,0,0, 0,1,1,0,1, 0,1};
    tv[15] = '{1,0,0,0,0,0, 0,0,0, 0,0,1,0, 4,3,0,0, 0,1,3,0,1, 0,1};
    tv[16] = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 4,3,0,0, 0,1,1,0,1, 0,0};
    tv[17] = '{1,0,1,4,'h44,1, 0,0,0, 0,0,0,0, 4,3,0,0,
               'h44,0,1,0,1, 0,0};
    tv[18] = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 4,3,0,0,
               'h44,0,0,0,1, 0,0};
    tv[19] = '{1,0,0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0};
    tv[20] = '{1,0,0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1};
    tv[21] = '{1,0,0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,2};
    tv[22] = '{1,0,0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,3};
    tv[23] = '{1,0,0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,0};
    tv[24] = '{1,0,0,0,0,0, 0,0,0, 0,1,0,0, 0,0,0,0, 0,0,0,0,0, 1,0};
    tv[25] = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0};
    tv[26] = '{1,0,0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0};
    tv[27] = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1};
    tv[28] = '{1,0,0,0,0,0, 0,0,0, 0,0,1,2, 0,0,0,0, 0,0,0,0,0, 1,1};
    tv[29] = '{1,0,0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,2};
    tv[30] = '{1,0,0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,3};
    tv[31] = '{1,0,0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0};
    tv[32] = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1};
    tv[33] = '{1,0,0,0,0,0, 0,0,0, 0,1,0,0, 0,0,0,0, 0,0,0,0,0, 1,1};
    tv[34] = '{1,0,0,0,0,0, 1,6,8, 0,0,0,0, 6,3,0,0, 0,0,0,0,1, 0,1};
    tv[35] = '{1,1,1,6,9,0, 1,5,3, 1,0,0,0, 6,3,0,0, 0,1,8,0,1, 0,1};
    tv[36] = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 6,3,0,0,
               9,0,0,'hAA,0, 0,0};
    tv[37] = '{0,0,0,0,0,0, 1,7,4, 1,0,0,0, 7,6,0,0, 0,0,0,9,0, 0,0};
    tv[38] = '{1,0,0,0,0,0, 0,0,0, 0,0,0,0, 7,6,0,0, 0,0,0,9,0, 0,0};

    idle();
    rst_in = 0;
    #12 rst_in = 1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_in);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_val0", i), 64'(rd_val[31:0]), 64'(tv[i].ev0));
      chk($sformatf("v%0d_dep0", i), 64'(rd_has_dep[0]), 64'(tv[i].eh0));
      chk($sformatf("v%0d_tag0", i), 64'(rd_dep[3:0]), 64'(tv[i].ed0));
      chk($sformatf("v%0d_qry0", i), 64'(rob_query_entry[3:0]),
          64'(tv[i].ed0));
      chk($sformatf("v%0d_val1", i), 64'(rd_val[63:32]), 64'(tv[i].ev1));
      chk($sformatf("v%0d_dep1", i), 64'(rd_has_dep[1]), 64'(tv[i].eh1));
      chk($sformatf("v%0d_full", i), 64'(ckpt_full), 64'(tv[i].efull));
      chk($sformatf("v%0d_ckid", i), 64'(ckpt_id_out), 64'(tv[i].eid));
    end

    // Async reset lands between clock edges
    @(negedge clk_in);
    idle();
    issue_valid = 1; issue_reg_id = 7; issue_rob_entry = 4;
    commit_valid = 1; commit_reg_id = 2; commit_data = 'h55;
    @(posedge clk_in);
    #2;
    idle();
    rd_id = {5'd2, 5'd7};
    #1;
    chk("pre_rst_dep7", 64'(rd_has_dep[0]), 64'd1);
    chk("pre_rst_tag7", 64'(rd_dep[3:0]), 64'd4);
    chk("pre_rst_val2", 64'(rd_val[63:32]), 64'h55);
    rst_in = 0;
    #1;
    chk("async_rst_dep7", 64'(rd_has_dep[0]), 64'd0);
    chk("async_rst_tag7", 64'(rd_dep[3:0]), 64'd0);
    chk("async_rst_val2", 64'(rd_val[63:32]), 64'd0);
    chk("async_rst_ckid", 64'(ckpt_id_out), 64'd0);
    chk("async_rst_full", 64'(ckpt_full), 64'd0);
    @(negedge clk_in);
    rst_in = 1;
    m_reset();

    // Randomized legal traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ev;
      logic        eh;
      logic [3:0]  ed;
      int          k;
      @(negedge clk_in);
      idle();
      rdy_in = ($urandom % 10) != 0;
      clear_in = ($urandom % 60) == 0;
      commit_valid = $urandom % 2;
      commit_reg_id = 5'($urandom % 8);
      commit_rob_entry = ($urandom % 3 != 0) ? m_t[commit_reg_id]
                                             : 4'($urandom);
      commit_data = $urandom;
      issue_valid = $urandom % 2;
      issue_reg_id = 5'($urandom % 8);
      issue_rob_entry = 4'($urandom);
      ckpt_release = m_q.size() > 0 && ($urandom % 4) == 0;
      ckpt_restore = m_q.size() > 0 && ($urandom % 6) == 0;
      if (ckpt_restore) begin
        k = int'($urandom % m_q.size());
        ckpt_restore_id = m_q[k].id;
        if (k == 0) ckpt_release = 0;
      end
      ckpt_save = m_q.size() < 4 && ($urandom % 3) == 0;
      rd_id = {5'($urandom % 8), 5'($urandom % 8)};
      rob_query_ready = 2'($urandom);
      rob_query_value = {$urandom, $urandom};
      #1;
      for (int p = 0; p < 2; p++) begin
        m_read(rd_id[p*5 +: 5], rob_query_ready[p],
               rob_query_value[p*32 +: 32], ev, eh, ed);
        chk($sformatf("r%0d_p%0d_val", c, p),
            64'(rd_val[p*32 +: 32]), 64'(ev));
        chk($sformatf("r%0d_p%0d_hdep", c, p),
            64'(rd_has_dep[p]), 64'(eh));
        chk($sformatf("r%0d_p%0d_tag", c, p),
            64'(rd_dep[p*4 +: 4]), 64'(ed));
        chk($sformatf("r%0d_p%0d_qry", c, p),
            64'(rob_query_entry[p*4 +: 4]), 64'(ed));
      end
      chk($sformatf("r%0d_full", c), 64'(ckpt_full),
          64'(m_q.size() == 4));
      chk($sformatf("r%0d_ckid", c), 64'(ckpt_id_out), 64'(m_tail));
      @(posedge clk_in);
      m_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
